// File: rtl/req_encoder_pkg.sv
// Shared sizes, FSM encoding and bit-order helpers for the request encoder.
package req_encoder_pkg;

    localparam int REQ_N  = 16;
    localparam int CODE_W = 4;
    localparam int CNT_W  = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    // Team decoder order puts weight 8 on bit 0; the mapping is a bit reversal,
    // so the same function converts index->code and code->index.
    function automatic logic [CODE_W-1:0] swap_order(input logic [CODE_W-1:0] val);
        logic [CODE_W-1:0] res;
        for (int i = 0; i < CODE_W; i++) begin
            res[i] = val[CODE_W-1-i];
        end
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [REQ_N-1:0] vec);
        logic [CNT_W-1:0] total;
        total = '0;
        for (int i = 0; i < REQ_N; i++) begin
            total = total + CNT_W'(vec[i]);
        end
        return total;
    endfunction

endpackage

// File: rtl/req_encoder_if.sv
// Request/code bundle between a producer/consumer (master) and req_encoder (slave).
interface req_encoder_if;
    import req_encoder_pkg::*;

    // Handshake: a code transfers on a rising clk edge where v=1 and rdy=1;
    // while v=1 and rdy=0 the slave holds x and v stable.
    logic                e;
    logic [REQ_N-1:0]    d;
    logic                rdy;
    logic [CODE_W-1:0]   x;
    logic                v;
    logic [CNT_W-1:0]    cnt;
    logic                ov;
    logic [0:0]          fsm;

    modport master (
        output e, d, rdy,
        input  x, v, cnt, ov, fsm
    );

    modport slave (
        input  e, d, rdy,
        output x, v, cnt, ov, fsm
    );

endinterface

// File: rtl/req_encoder_pri_enc16.sv
// Lowest-set-index priority encoder; code is emitted in team bit order.
module pri_enc16
    import req_encoder_pkg::*;
(
    input  logic [REQ_N-1:0]  vec,
    output logic [CODE_W-1:0] code,
    output logic              any
);

    always_comb begin
        code = '0;
        // Scan downward so the lowest set index is written last and wins.
        for (int i = REQ_N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                code = swap_order(CODE_W'(i));
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/req_encoder.sv
// Pending-request register with a two-state presenter that serves the lowest index first.
module req_encoder
    import req_encoder_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    req_encoder_if.slave  bus
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_SHOW = SHOW;

    logic [0:0]        state;
    logic [REQ_N-1:0]  p;
    logic [CODE_W-1:0] x_q;
    logic              v_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ov_q;

    logic              xfer;
    logic [REQ_N-1:0]  served;
    logic [REQ_N-1:0]  set_mask;
    logic [REQ_N-1:0]  p_rest;
    logic [REQ_N-1:0]  p_next;
    logic              ov_next;
    logic [CODE_W-1:0] win_code;
    logic              win_any;

    always_comb begin
        xfer     = (state == ST_SHOW) && bus.rdy;
        served   = '0;
        if (xfer) begin
            served = {{(REQ_N-1){1'b0}}, 1'b1} << swap_order(x_q);
        end
        set_mask = bus.e ? bus.d : '0;
        p_rest   = p & ~served;
        p_next   = p_rest | set_mask;
        ov_next  = |(set_mask & p & ~served);
    end

    // The winner is taken from p minus the bit being served; same-edge arrivals
    // only reach p_next, so they wait one edge before they can be presented.
    pri_enc16 u_pri (
        .vec  (p_rest),
        .code (win_code),
        .any  (win_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            p     <= '0;
            x_q   <= '0;
            v_q   <= 1'b0;
            cnt_q <= '0;
            ov_q  <= 1'b0;
        end else begin
            p     <= p_next;
            cnt_q <= popcount(p_next);
            ov_q  <= ov_next;
            case (state)
                ST_IDLE: begin
                    if (bus.e && win_any) begin
                        x_q   <= win_code;
                        v_q   <= 1'b1;
                        state <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (bus.rdy) begin
                        if (bus.e && win_any) begin
                            x_q <= win_code;
                        end else begin
                            v_q   <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    v_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.x   = x_q;
    assign bus.v   = v_q;
    assign bus.cnt = cnt_q;
    assign bus.ov  = ov_q;
    assign bus.fsm = state;

endmodule

// File: tb/tb_req_encoder.sv
// Directed bench for req_encoder: latency, hold, drain order, merge pulse, enable and reset.
module tb_req_encoder;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [3:0] exp_q[$];

    req_encoder_if bus ();

    req_encoder u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are applied 1ns after an edge; outputs are read 1ns after the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [15:0] d, input logic rdy);
        bus.e   = e;
        bus.d   = d;
        bus.rdy = rdy;
    endtask

    // Team decoder: x[0] weight 8 ... x[3] weight 1.
    function automatic logic [15:0] team_decode(input logic [3:0] x);
        logic [3:0] idx;
        idx = {x[0], x[1], x[2], x[3]};
        return 16'h0001 << idx;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 16'h0000, 1'b0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        do_reset();
        check("rst_v", 32'(bus.v), 0);
        check("rst_x", 32'(bus.x), 0);
        check("rst_cnt", 32'(bus.cnt), 0);
        check("rst_ov", 32'(bus.ov), 0);
        check("rst_fsm", 32'(bus.fsm), 0);

        // Single request at index 4: two edges to v=1.
        drive(1'b1, 16'h0010, 1'b1);
        step();
        check("lat_v_early", 32'(bus.v), 0);
        check("lat_cnt1", 32'(bus.cnt), 1);
        drive(1'b1, 16'h0000, 1'b1);
        step();
        check("lat_v", 32'(bus.v), 1);
        check("lat_x", 32'(bus.x), 32'b0010);
        check("lat_cnt", 32'(bus.cnt), 1);
        step();
        check("lat_done_v", 32'(bus.v), 0);
        check("lat_done_cnt", 32'(bus.cnt), 0);

        // Indices 0 and 15 with rdy held low: stable hold then back-to-back.
        drive(1'b1, 16'h8001, 1'b0);
        step();
        check("hold_cnt", 32'(bus.cnt), 2);
        drive(1'b1, 16'h0000, 1'b0);
        step();
        check("hold_load_x", 32'(bus.x), 32'b0000);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_x", 32'(bus.x), 32'b0000);
            check("hold_v", 32'(bus.v), 1);
        end
        bus.rdy = 1'b1;
        step();
        check("b2b_x", 32'(bus.x), 32'b1111);
        check("b2b_v", 32'(bus.v), 1);
        check("b2b_cnt", 32'(bus.cnt), 1);
        step();
        check("b2b_end_v", 32'(bus.v), 0);

        // All 16 pending, drained in index order with no bubble.
        drive(1'b1, 16'hFFFF, 1'b1);
        step();
        check("full_cnt", 32'(bus.cnt), 16);
        bus.d = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(4'(k));
        end
        for (int k = 0; k < 16; k++) begin
            logic [3:0] exp_idx;
            step();
            exp_idx = exp_q.pop_front();
            check("drain_v", 32'(bus.v), 1);
            check("drain_dec", 32'(team_decode(bus.x)), 32'(16'h0001 << exp_idx));
            check("drain_cnt", 32'(bus.cnt), 32'(16 - k));
        end
        step();
        check("drain_end_v", 32'(bus.v), 0);
        check("drain_end_cnt", 32'(bus.cnt), 0);
        check("drain_q_empty", 32'(exp_q.size()), 0);

        // Re-request of pending index 3 merges and pulses ov.
        drive(1'b1, 16'h0008, 1'b0);
        step();
        check("ov_first", 32'(bus.ov), 0);
        step();
        check("ov_pulse", 32'(bus.ov), 1);
        check("ov_cnt", 32'(bus.cnt), 1);
        check("ov_x", 32'(bus.x), 32'b1100);
        bus.d = 16'h0000;
        step();
        check("ov_clear", 32'(bus.ov), 0);
        drive(1'b1, 16'h0008, 1'b1);
        step();
        check("setwin_ov", 32'(bus.ov), 0);
        check("setwin_cnt", 32'(bus.cnt), 1);
        check("setwin_v", 32'(bus.v), 0);
        bus.d = 16'h0000;
        step();
        check("reserve_v", 32'(bus.v), 1);
        check("reserve_x", 32'(bus.x), 32'b1100);
        step();
        check("reserve_done_cnt", 32'(bus.cnt), 0);

        // Enable dropped mid-handshake.
        drive(1'b1, 16'h0003, 1'b0);
        step();
        bus.d = 16'h0000;
        step();
        check("en_load_x", 32'(bus.x), 32'b0000);
        drive(1'b0, 16'h0000, 1'b0);
        step();
        check("en_hold_v", 32'(bus.v), 1);
        bus.d = 16'h0004;
        step();
        check("en_hold_x", 32'(bus.x), 32'b0000);
        check("en_ignore_cnt", 32'(bus.cnt), 2);
        drive(1'b0, 16'h0000, 1'b1);
        step();
        check("en_xfer_v", 32'(bus.v), 0);
        check("en_xfer_cnt", 32'(bus.cnt), 1);
        step();
        check("en_idle_v", 32'(bus.v), 0);
        bus.e = 1'b1;
        step();
        check("en_resume_v", 32'(bus.v), 1);
        check("en_resume_x", 32'(bus.x), 32'b1000);
        step();
        check("en_resume_done", 32'(bus.cnt), 0);

        // Reset during SHOW with five pending.
        drive(1'b1, 16'h001F, 1'b0);
        step();
        check("rs_cnt5", 32'(bus.cnt), 5);
        step();
        check("rs_ov_pre", 32'(bus.ov), 1);
        check("rs_v_pre", 32'(bus.v), 1);
        rst = 1'b1;
        drive(1'b1, 16'h001F, 1'b1);
        step();
        rst = 1'b0;
        check("rs_v", 32'(bus.v), 0);
        check("rs_x", 32'(bus.x), 0);
        check("rs_cnt", 32'(bus.cnt), 0);
        check("rs_ov", 32'(bus.ov), 0);
        drive(1'b1, 16'h0000, 1'b1);
        step();
        check("rs_after_v", 32'(bus.v), 0);
        check("rs_after_cnt", 32'(bus.cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/req_encoder.md
REQ_ENCODER -- requirements
Module: req_encoder

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-003 e  input  1  enable: gates capture of new requests and loading of new codes.
REQ-004 d  input  16  request lines; any number may be high in a cycle.
REQ-005 rdy  input  1  consumer ready; a transfer occurs on a clk edge where v=1 and rdy=1.
REQ-006 x  output  4  encoded index of the presented request, registered.
REQ-007 v  output  1  x is valid, registered.
REQ-008 cnt  output  5  number of pending requests, 0..16, registered.
REQ-009 ov  output  1  one-cycle pulse: a request arrived for an already-pending index (merged, not queued twice).

Function
REQ-010 x SHALL use the team decoder bit order: x[0] carries weight 8 and x[3] carries weight 1, so that decoding x with e=1 reproduces the one-hot of the served index.
REQ-011 Pending register p[15:0]: with e=1, each edge sets p[i] for every d[i]=1; with e=0, d is ignored.
REQ-012 A served bit SHALL be cleared on its transfer edge; if d[i]=1 with e=1 on that same edge, set wins and p[i] stays 1.
REQ-013 ov SHALL be 1 on the edge after any cycle where e=1, d[i]=1 and p[i]=1 with bit i not being cleared that edge, otherwise 0.
REQ-014 cnt SHALL equal popcount(p) after every edge; width 5 so 16 is representable.
REQ-015 Priority: lowest set index of p wins (index 0 highest).
REQ-016 State IDLE: v=0; if e=1 and p!=0, load x with the winning index, set v=1 and go to SHOW.
REQ-017 State SHOW: x and v SHALL remain stable while rdy=0, regardless of e or d.
REQ-018 SHOW with rdy=1: clear the served bit; if e=1 and (p minus the served bit)!=0, load the next winner with v=1 on the same edge (back-to-back, no bubble); otherwise v=0 and go to IDLE.
REQ-019 Requests arriving on the transfer edge SHALL NOT be considered for the back-to-back load; they become eligible on the next edge.
REQ-020 Latency: request on d in cycle N (p empty, IDLE, e=1) SHALL appear as v=1 with its x after the edge ending cycle N+1.
REQ-021 Deasserting e during SHOW SHALL NOT drop the presented code; the handshake completes, then the block stays IDLE until e=1.
REQ-022 All 16 pending: cnt=16, no wrap; 16 transfers drain p in index order 0..15.

Reset
REQ-023 On rst=1 at an edge: p=0, x=0, v=0, cnt=0, ov=0, state IDLE; takes priority over all other inputs.
REQ-024 Reset mid-handshake SHALL discard the presented code and all pending requests without a transfer.

Structure
REQ-025 Shared package SHALL hold the request count (16), the code width (4), the count width (5) and the two-state enumeration IDLE/SHOW.
REQ-026 One combinational sub-module pri_enc16 SHALL map a 16-bit vector to the lowest-set-index code in team bit order, plus a nonzero flag; req_encoder holds all registers and the state machine.

Verification
REQ-027 Reset, then e=1, d=16'h0010 for one cycle, rdy=1 -> two edges later v=1, x=4'b0010 (index 4), cnt=1; next edge v=0, cnt=0.
REQ-028 d=16'h8001 in one cycle, rdy=0 for 3 cycles then 1 -> x=4'b0000 held stable 3 cycles, then x=4'b1111 back-to-back, then v=0.
REQ-029 d=16'hFFFF, rdy=1 -> cnt=16, then 16 consecutive transfers of indices 0..15 with no bubble, and every x decodes through the team decoder to the matching one-hot.
REQ-030 Index 3 pending, re-request d[3] -> ov pulses 1 cycle, cnt unchanged; d[3] on its own transfer edge -> p[3] stays 1, index 3 served again later.
REQ-031 e dropped to 0 during SHOW with rdy=0 -> x, v held; rdy=1 -> transfer completes, v=0, no new load until e=1.
REQ-032 rst=1 during SHOW with 5 pending -> next edge v=0, x=0, cnt=0, ov=0, no transfer counted.
